// File: rtl/capture_ctrl_pkg.sv
// rtl/capture_ctrl_pkg.sv - shared state encoding and count scaling for the capture sequencer
package capture_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DELAY   = 2'd2,
    READOUT = 2'd3
  } state_t;

  // Count fields are programmed in units of CNT_MUL samples.
  localparam int CNT_MUL   = 4;
  localparam int CNT_SHIFT = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/capture_ctrl_ld_dcnt.sv
// rtl/capture_ctrl_ld_dcnt.sv - loadable down-counter with zero/one flags
// Load wins over decrement; decrement stops at zero.
module ld_dcnt #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         one
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - logic-analyzer capture sequencer: arm, circular write, delay count, readout
// Optional CAPTURE_FILL_GUARD_EN holds off the trigger until enough post-arm samples exist.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_cnt_i,
  input  logic [2*CNT_W-1:0] cnt_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              stb_i,
  input  logic              run_i,
  output logic              trg_arm_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              idle_o
);

  localparam int EW = CNT_W + CNT_SHIFT;
  localparam int XW = max_int(EW, ADDR_W + 1);
  localparam logic [XW-1:0] DEPTH = XW'(1) << ADDR_W;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  rd_field, dly_field;
  logic [ADDR_W-1:0] wptr, raddr;
  logic [XW-1:0]     eff_rd_raw, eff_rd, eff_dly;

  logic arm_go, dly_load, dly_dec, rd_load, rd_dec, raddr_load, fill_ok;
  logic [XW-1:0] dly_cnt, rd_cnt;
  logic dly_zero, dly_one, rd_zero, rd_one;

  assign eff_rd_raw = (XW'(rd_field) + XW'(1)) << CNT_SHIFT;
  assign eff_rd     = (eff_rd_raw > DEPTH) ? DEPTH : eff_rd_raw;
  assign eff_dly    = (XW'(dly_field) + XW'(1)) << CNT_SHIFT;

`ifdef CAPTURE_FILL_GUARD_EN
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W+1)'(1) << ADDR_W;
  logic [ADDR_W:0] fill_q;
  logic [XW-1:0]   min_dr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_q <= '0;
    end else if (arm_go) begin
      fill_q <= '0;
    end else if (we_o && (fill_q != FILL_MAX)) begin
      fill_q <= fill_q + (ADDR_W+1)'(1);
    end
  end

  // Trigger only once the oldest sample to be read back was written after arm.
  assign min_dr  = (eff_dly < eff_rd) ? eff_dly : eff_rd;
  assign fill_ok = (XW'(fill_q) >= (eff_rd - min_dr));
`else
  assign fill_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    trg_arm_o  = 1'b0;
    we_o       = 1'b0;
    rd_valid_o = 1'b0;
    arm_go     = 1'b0;
    dly_load   = 1'b0;
    dly_dec    = 1'b0;
    rd_load    = 1'b0;
    rd_dec     = 1'b0;
    raddr_load = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d   = ARMED;
            trg_arm_o = 1'b1;
            arm_go    = 1'b1;
          end
        end
        ARMED: begin
          we_o = stb_i;
          if (run_i && fill_ok) begin
            state_d  = DELAY;
            dly_load = 1'b1;
          end
        end
        DELAY: begin
          we_o = stb_i;
          if (stb_i) begin
            dly_dec = 1'b1;
            if (dly_one) begin
              state_d    = READOUT;
              rd_load    = 1'b1;
              raddr_load = 1'b1;
            end
          end
        end
        READOUT: begin
          rd_valid_o = 1'b1;
          if (rd_ready_i) begin
            rd_dec = 1'b1;
            if (rd_one) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rd_field  <= '0;
      dly_field <= '0;
      wptr      <= '0;
      raddr     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && set_cnt_i && !abort_i) begin
        {dly_field, rd_field} <= cnt_i;
      end
      if (arm_go) begin
        wptr <= '0;
      end else if (we_o) begin
        wptr <= wptr + ADDR_W'(1);
      end
      // Readout starts at the final delay write and walks backwards in time.
      if (raddr_load) begin
        raddr <= wptr;
      end else if (rd_dec) begin
        raddr <= raddr - ADDR_W'(1);
      end
    end
  end

  ld_dcnt #(.W(XW)) u_dly_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (dly_load),
    .val  (eff_dly),
    .dec  (dly_dec),
    .cnt  (dly_cnt),
    .zero (dly_zero),
    .one  (dly_one)
  );

  ld_dcnt #(.W(XW)) u_rd_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (rd_load),
    .val  (eff_rd),
    .dec  (rd_dec),
    .cnt  (rd_cnt),
    .zero (rd_zero),
    .one  (rd_one)
  );

  logic unused_cnt;
  assign unused_cnt = ^{dly_cnt, rd_cnt, dly_zero, rd_zero};

  assign waddr_o = wptr;
  assign raddr_o = raddr;
  assign idle_o  = (state_q == IDLE);

endmodule
